// File: rtl/axi4_lite_reg_slice.sv
// AXI4-Lite register slice: one 2-entry skid unit per channel, all outputs registered.
// Optional statistics counters are enabled with `define AXIL_SLICE_STATS_EN.

module axi4_lite_reg_slice_skid #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               src_vld_i,
  output logic               src_rdy_o,
  input  logic [width_p-1:0] src_dat_i,
  output logic               dst_vld_o,
  input  logic               dst_rdy_i,
  output logic [width_p-1:0] dst_dat_o
);
  logic               main_vld_q, main_vld_d;
  logic               skid_vld_q, skid_vld_d;
  logic               rdy_q, rdy_d;
  logic [width_p-1:0] main_dat_q, skid_dat_q;
  logic               in_hs, out_hs;
  logic               load_main_in, load_main_skid, load_skid;

  assign in_hs     = src_vld_i & rdy_q;
  assign out_hs    = main_vld_q & dst_rdy_i;
  assign src_rdy_o = rdy_q;
  assign dst_vld_o = main_vld_q;
  assign dst_dat_o = main_dat_q;

  // Skid only fills while ready is high, and ready drops once it is full,
  // so a skid drain never coincides with a new input beat.
  always_comb begin
    main_vld_d     = main_vld_q;
    skid_vld_d     = skid_vld_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (out_hs && skid_vld_q) begin
      main_vld_d     = 1'b1;
      skid_vld_d     = 1'b0;
      load_main_skid = 1'b1;
    end else if (in_hs && (!main_vld_q || out_hs)) begin
      main_vld_d   = 1'b1;
      load_main_in = 1'b1;
    end else if (in_hs) begin
      skid_vld_d = 1'b1;
      load_skid  = 1'b1;
    end else if (out_hs) begin
      main_vld_d = 1'b0;
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_main_skid)    main_dat_q <= skid_dat_q;
    else if (load_main_in) main_dat_q <= src_dat_i;
    if (load_skid)         skid_dat_q <= src_dat_i;
  end
endmodule

module axi4_lite_reg_slice #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64,
  parameter int cnt_width_p  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [addr_width_p-1:0]   s_awaddr_i,
  input  logic [2:0]                s_awprot_i,
  input  logic                      s_awvalid_i,
  output logic                      s_awready_o,
  input  logic [data_width_p-1:0]   s_wdata_i,
  input  logic [data_width_p/8-1:0] s_wstrb_i,
  input  logic                      s_wvalid_i,
  output logic                      s_wready_o,
  output logic [1:0]                s_bresp_o,
  output logic                      s_bvalid_o,
  input  logic                      s_bready_i,
  input  logic [addr_width_p-1:0]   s_araddr_i,
  input  logic [2:0]                s_arprot_i,
  input  logic                      s_arvalid_i,
  output logic                      s_arready_o,
  output logic [data_width_p-1:0]   s_rdata_o,
  output logic [1:0]                s_rresp_o,
  output logic                      s_rvalid_o,
  input  logic                      s_rready_i,
  output logic [addr_width_p-1:0]   m_awaddr_o,
  output logic [2:0]                m_awprot_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [data_width_p-1:0]   m_wdata_o,
  output logic [data_width_p/8-1:0] m_wstrb_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  input  logic [1:0]                m_bresp_i,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  output logic [addr_width_p-1:0]   m_araddr_o,
  output logic [2:0]                m_arprot_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [data_width_p-1:0]   m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  output logic [cnt_width_p-1:0]    wr_cnt_o,
  output logic [cnt_width_p-1:0]    rd_cnt_o
);
  localparam int a_w_lp = addr_width_p + 3;
  localparam int w_w_lp = data_width_p + data_width_p/8;
  localparam int r_w_lp = data_width_p + 2;

  axi4_lite_reg_slice_skid #(.width_p(a_w_lp)) aw_skid (
    .clk_i, .reset_n_i,
    .src_vld_i(s_awvalid_i), .src_rdy_o(s_awready_o), .src_dat_i({s_awaddr_i, s_awprot_i}),
    .dst_vld_o(m_awvalid_o), .dst_rdy_i(m_awready_i), .dst_dat_o({m_awaddr_o, m_awprot_o}));

  axi4_lite_reg_slice_skid #(.width_p(w_w_lp)) w_skid (
    .clk_i, .reset_n_i,
    .src_vld_i(s_wvalid_i), .src_rdy_o(s_wready_o), .src_dat_i({s_wdata_i, s_wstrb_i}),
    .dst_vld_o(m_wvalid_o), .dst_rdy_i(m_wready_i), .dst_dat_o({m_wdata_o, m_wstrb_o}));

  axi4_lite_reg_slice_skid #(.width_p(2)) b_skid (
    .clk_i, .reset_n_i,
    .src_vld_i(m_bvalid_i), .src_rdy_o(m_bready_o), .src_dat_i(m_bresp_i),
    .dst_vld_o(s_bvalid_o), .dst_rdy_i(s_bready_i), .dst_dat_o(s_bresp_o));

  axi4_lite_reg_slice_skid #(.width_p(a_w_lp)) ar_skid (
    .clk_i, .reset_n_i,
    .src_vld_i(s_arvalid_i), .src_rdy_o(s_arready_o), .src_dat_i({s_araddr_i, s_arprot_i}),
    .dst_vld_o(m_arvalid_o), .dst_rdy_i(m_arready_i), .dst_dat_o({m_araddr_o, m_arprot_o}));

  axi4_lite_reg_slice_skid #(.width_p(r_w_lp)) r_skid (
    .clk_i, .reset_n_i,
    .src_vld_i(m_rvalid_i), .src_rdy_o(m_rready_o), .src_dat_i({m_rdata_i, m_rresp_i}),
    .dst_vld_o(s_rvalid_o), .dst_rdy_i(s_rready_i), .dst_dat_o({s_rdata_o, s_rresp_o}));

`ifdef AXIL_SLICE_STATS_EN
  logic [cnt_width_p-1:0] wr_cnt_q, rd_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (s_bvalid_o && s_bready_i) wr_cnt_q <= wr_cnt_q + cnt_width_p'(1);
      if (s_rvalid_o && s_rready_i) rd_cnt_q <= rd_cnt_q + cnt_width_p'(1);
    end
  end

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;
`else
  assign wr_cnt_o = '0;
  assign rd_cnt_o = '0;
`endif
endmodule
